// File: rtl/c96_pkg.sv
// Shared types for the Chameleon96 reset sequencer: sequencer states and the sticky reset-cause code.
package c96_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_BTN = 2'b01,
    CAUSE_WDT = 2'b10
  } rst_cause_t;

endpackage

// File: rtl/c96_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter, accepted level and a press pulse.
module c96_debounce
  import c96_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic pressed_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("c96_debounce: DEB_CYCLES must be >= 2");
  end

  logic             sync1_q, sync2_q;
  logic             accRel_q, accRel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // A disagreement must persist for DEB_CYCLES consecutive samples before the accepted level moves.
  always_comb begin
    cnt_d    = '0;
    accRel_d = accRel_q;
    flip     = 1'b0;
    if (sync2_q != accRel_q) begin
      if (cnt_q == CNT_LAST) begin
        flip     = 1'b1;
        accRel_d = ~accRel_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      accRel_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_ni;
      sync2_q  <= sync1_q;
      accRel_q <= accRel_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed_o = ~accRel_q;
  assign press_o   = flip & accRel_q;

endmodule

// File: rtl/c96_reset_seq.sv
// Reset sequencer for the servant SoC: stretched active-high reset, sticky cause code and a heartbeat LED.
module c96_reset_seq
  import c96_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int DEB_CYCLES  = 50000,
  parameter int WDT_CYCLES  = 0,
  parameter int HB_DIV      = 25
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_n,
  input  logic       i_wdt_kick,
  output logic       o_rst,
  output logic [1:0] o_rst_cause,
  output logic       o_heartbeat
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int HB_W   = HB_DIV + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("c96_reset_seq: HOLD_CYCLES must be >= 1");
  end
  if (WDT_CYCLES < 0) begin : g_bad_wdt
    $error("c96_reset_seq: WDT_CYCLES must be >= 0");
  end

  rst_state_t        state_q, state_d;
  rst_cause_t        cause_q, cause_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [HB_W-1:0]   hbCnt_q;
  logic              rst_q;
  logic              btnPressed, btnPress;
  logic              wdtExpire;

  c96_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .btn_ni   (i_btn_n),
    .pressed_o(btnPressed),
    .press_o  (btnPress)
  );

  // Watchdog: runs only while the SoC is out of reset; a kick beats a same-cycle expiry.
  if (WDT_CYCLES != 0) begin : g_wdt
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdtCnt_q, wdtCnt_d;

    always_comb begin
      wdtCnt_d = '0;
      if (state_q == RUN && !i_wdt_kick && wdtCnt_q != WDT_LAST) begin
        wdtCnt_d = wdtCnt_q + WDT_W'(1);
      end
    end

    assign wdtExpire = (state_q == RUN) && !i_wdt_kick && (wdtCnt_q == WDT_LAST);

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        wdtCnt_q <= '0;
      end else begin
        wdtCnt_q <= wdtCnt_d;
      end
    end
  end else begin : g_no_wdt
    logic unusedKick;
    assign unusedKick = i_wdt_kick;
    assign wdtExpire  = 1'b0;
  end

  // The button outranks the watchdog, and the cause code only moves when RUN drops back to HOLD.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    holdCnt_d = holdCnt_q;
    case (state_q)
      HOLD: begin
        if (btnPress || btnPressed) begin
          holdCnt_d = '0;
        end else if (holdCnt_q == HOLD_LAST) begin
          state_d   = RUN;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (btnPress) begin
          state_d   = HOLD;
          cause_d   = CAUSE_BTN;
          holdCnt_d = '0;
        end else if (wdtExpire) begin
          state_d   = HOLD;
          cause_d   = CAUSE_WDT;
          holdCnt_d = '0;
        end
      end
      default: begin
        state_d   = HOLD;
        holdCnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= HOLD;
      cause_q   <= CAUSE_POR;
      holdCnt_q <= '0;
      rst_q     <= 1'b1;
      hbCnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      holdCnt_q <= holdCnt_d;
      rst_q     <= (state_d == HOLD);
      hbCnt_q   <= hbCnt_q + HB_W'(1);
    end
  end

  assign o_rst       = rst_q;
  assign o_rst_cause = cause_q;
  assign o_heartbeat = hbCnt_q[HB_DIV];

endmodule
